// File: rtl/sr_latch_driver.sv
`timescale 1ns/1ps
// sr_latch_driver
//   Command-side driver for a NOR-style SR latch. Turns a valid/ready stream
//   of set/clear commands into clean s or r pulses of PULSE_W cycles, follows
//   each pulse with GAP_W cycles of s=r=0, then compares the synchronized
//   latch output against the commanded level and flags any mismatch.
//
// Parameters
//   PULSE_W : cycles s (or r) is held high per command (3 .. 2**CNT_W)
//   GAP_W   : cycles of s=r=0 after each pulse (0 allowed)
//   CNT_W   : width of the shared pulse/gap cycle counter
//
// Ports
//   clk       in  : clock, rising edge
//   rst_n     in  : asynchronous active-low reset, synchronous release upstream
//   cmd_valid in  : command request
//   cmd_set   in  : 1 = set (pulse s), 0 = clear (pulse r); qualified by cmd_valid
//   cmd_ready out : driver accepts a command on this cycle's edge
//   s, r      out : registered latch drives, never high together
//   q_fb      in  : latch output, asynchronous to clk
//   busy      out : high while a pulse or gap is in progress
//   done      out : one-cycle strobe at the end of each pulse
//   err       out : one-cycle strobe alongside done when q disagrees with the command
module sr_latch_driver #(
  parameter int PULSE_W = 4,
  parameter int GAP_W   = 2,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmd_valid,
  input  logic cmd_set,
  output logic cmd_ready,
  output logic s,
  output logic r,
  input  logic q_fb,
  output logic busy,
  output logic done,
  output logic err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // The counter is loaded with "cycles - 1" so that the state exits on the
  // edge where it reads zero.
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_W > 0) ? (GAP_W - 1) : 0);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg,   cnt_next;
  logic             lvl_reg,   lvl_next;
  logic             s_reg,     s_next;
  logic             r_reg,     r_next;
  logic             done_reg,  done_next;
  logic             err_reg,   err_next;
  logic             q_meta_reg;
  logic             q_sync_reg;

  // Two-flop synchronizer: q_fb is driven by an unclocked latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_meta_reg <= 1'b0;
      q_sync_reg <= 1'b0;
    end else begin
      q_meta_reg <= q_fb;
      q_sync_reg <= q_meta_reg;
    end
  end

  // State register. The asynchronous clear drops s/r the moment rst_n falls,
  // so a pulse cut short by reset never needs a clock edge to release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      lvl_reg   <= 1'b0;
      s_reg     <= 1'b0;
      r_reg     <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      lvl_reg   <= lvl_next;
      s_reg     <= s_next;
      r_reg     <= r_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  // Next-state logic. s_next and r_next are only ever assigned as a value and
  // its complement under the same condition (or both zero), so s and r are
  // structurally exclusive in every cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    lvl_next   = lvl_reg;
    s_next     = 1'b0;
    r_next     = 1'b0;
    done_next  = 1'b0;
    err_next   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          // Drive starts on the accepting edge, using the incoming level.
          lvl_next   = cmd_set;
          cnt_next   = PULSE_LOAD;
          s_next     = cmd_set;
          r_next     = ~cmd_set;
          state_next = ST_PULSE;
        end
      end

      ST_PULSE: begin
        if (cnt_reg == '0) begin
          // Last pulse cycle: release the drive and check the latch. By now
          // the latch has had PULSE_W-1 edges to reach q_sync_reg.
          done_next = 1'b1;
          err_next  = (q_sync_reg != lvl_reg);
          if (GAP_W > 0) begin
            cnt_next   = GAP_LOAD;
            state_next = ST_GAP;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
          s_next   = lvl_reg;
          r_next   = ~lvl_reg;
        end
      end

      ST_GAP: begin
        if (cnt_reg == '0) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // cmd_ready is held low while rst_n is asserted even though the state
  // register already reads IDLE.
  assign cmd_ready = (state_reg == ST_IDLE) & rst_n;
  assign busy      = (state_reg != ST_IDLE);
  assign s         = s_reg;
  assign r         = r_reg;
  assign done      = done_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_sr_latch_driver.sv
`timescale 1ns/1ps
// Testbench for sr_latch_driver with a behavioural SR latch on q_fb.
// The stimulus thread pushes one expectation per accepted command; a
// monitor thread pops it when done strobes and checks err, latency and the
// latch level. Pulse widths and s&r exclusivity are checked every cycle.
module tb_sr_latch_driver;

  localparam int PULSE_W = 4;
  localparam int GAP_W   = 2;
  localparam int PERIOD  = PULSE_W + GAP_W + 1;

  logic clk = 1'b0;
  logic rst_n;
  logic cmd_valid;
  logic cmd_set;
  logic cmd_ready;
  logic s;
  logic r;
  logic q_fb;
  logic busy;
  logic done;
  logic err;

  logic latch_q = 1'b0;
  logic stuck;
  int   cyc = 0;

  typedef struct {
    int   acc;
    logic err;
    logic lvl;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  sr_latch_driver #(
    .PULSE_W(PULSE_W),
    .GAP_W  (GAP_W),
    .CNT_W  (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_set  (cmd_set),
    .cmd_ready(cmd_ready),
    .s        (s),
    .r        (r),
    .q_fb     (q_fb),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural NOR latch: holds its state while s=r=0.
  always @(posedge s or posedge r) begin
    if (s && !r)      latch_q <= 1'b1;
    else if (r && !s) latch_q <= 1'b0;
  end

  assign q_fb = stuck ? 1'b0 : latch_q;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 100000", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Waits (bounded) for cmd_ready, presents the command and returns the
  // cycle index right after the accepting edge.
  task automatic issue(input logic set, input logic exp_err, input logic push,
                       input logic hold, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", int'(cmd_ready), 1);
    cmd_set   = set;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    if (push) sb.push_back('{acc: acc, err: exp_err, lvl: set});
    if (!hold) cmd_valid = 1'b0;
    $display("cmd accepted cycle=%0d set=%0b exp_err=%0b tracked=%0b", acc, set, exp_err, push);
  endtask

  initial begin
    int a0, a1, a2, h0, h1, h2, m0, f0, n, plen;
    exp_t e;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_set   = 1'b0;
    stuck     = 1'b0;
    plen      = 0;

    fork
      forever begin
        @(negedge clk);
        checks++;
        assert (!(s && r)) else begin
          failures++;
          $display("FAIL s_and_r: got s=%0b r=%0b required not both 1 (cycle %0d)", s, r, cyc);
        end
        if (!rst_n) begin
          plen = 0;
        end else if (s || r) begin
          plen++;
        end else if (plen != 0) begin
          check("pulse_width", plen, PULSE_W);
          plen = 0;
        end
        if (done) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            check("done_latency", cyc - e.acc, PULSE_W);
            check("err", int'(err), int'(e.err));
            check("latch_q", int'(latch_q), int'(e.lvl));
            $display("done cycle=%0d err=%0b latch_q=%0b", cyc, err, latch_q);
          end
        end else if (err) begin
          check("err_without_done", int'(err), 0);
        end
      end
    join_none

    // 1. Reset
    repeat (3) @(negedge clk);
    check("rst_hold_s", int'(s), 0);
    check("rst_hold_r", int'(r), 0);
    check("rst_hold_busy", int'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_s", int'(s), 0);
    check("rst_r", int'(r), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_ready", int'(cmd_ready), 1);

    // 2./3. Set then clear back to back
    issue(1'b1, 1'b0, 1'b1, 1'b0, a0);
    issue(1'b0, 1'b0, 1'b1, 1'b0, a1);
    check("set_clear_spacing", a1 - a0, PERIOD);

    // 4. Stuck feedback on a set command
    stuck = 1'b1;
    issue(1'b1, 1'b1, 1'b1, 1'b0, a2);
    repeat (PULSE_W + 2) @(negedge clk);
    check("stuck_busy_gap", int'(busy), 1);
    stuck = 1'b0;
    @(negedge clk);
    check("stuck_idle_busy", int'(busy), 0);
    check("stuck_idle_ready", int'(cmd_ready), 1);

    // 5. cmd_valid held high across three commands (first matches latch level)
    issue(1'b1, 1'b0, 1'b1, 1'b1, h0);
    issue(1'b0, 1'b0, 1'b1, 1'b1, h1);
    issue(1'b1, 1'b0, 1'b1, 1'b0, h2);
    check("held_spacing_1", h1 - h0, PERIOD);
    check("held_spacing_2", h2 - h1, PERIOD);

    // 6. Reset in cycle 2 of a clear pulse
    issue(1'b0, 1'b0, 1'b0, 1'b0, m0);
    @(posedge clk);
    #2;
    check("mid_pre_r", int'(r), 1);
    rst_n = 1'b0;
    #1;
    check("mid_async_s", int'(s), 0);
    check("mid_async_r", int'(r), 0);
    check("mid_async_busy", int'(busy), 0);
    check("mid_async_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rel_ready", int'(cmd_ready), 1);
    check("mid_rel_busy", int'(busy), 0);
    check("mid_rel_done", int'(done), 0);
    repeat (10) @(negedge clk);

    // Normal operation after the interrupted pulse
    issue(1'b1, 1'b0, 1'b1, 1'b0, f0);

    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", sb.size(), 0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
